serdes_tx_arbiter: RTL and testbench
====================================

# serdes_tx_arbiter

Round-robin scheduler that shares the single-bit `dout` serial link of the serdes datapath between `N_REQ` parallel-word producers. Each producer hands over a `DATA_W`-bit word with a two-phase (toggle) req/ack handshake. The block frames each granted word as start bit, requester ID, then data MSB-first, and shifts it out one bit per clock. It sits between the parallel producers and the serial input of the serdes.

## Interface
- `N_REQ`, 4, number of requesters; legal range 2..16. `ID_W = $clog2(N_REQ)` is derived.
- `DATA_W`, 8, word width per requester; legal range 1..32.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req` in N_REQ: per-requester two-phase request. A toggle means a word is offered. Synchronous to `clk`.
- `data` in N_REQ*DATA_W: word of requester i at `[i*DATA_W +: DATA_W]`. Must be stable while `req[i] != ack[i]`.
- `ack` out N_REQ: per-requester two-phase acknowledge, registered.
- `dout` out 1: serial frame output, registered. Idle level 0.
- `busy` out 1: high while a frame is in progress (state ≠ IDLE).
- `grant_id` out ID_W: index of the requester whose frame is in progress. Holds its last value when idle.

## Operation
- Requester i is pending when `req[i] ^ ack[i]`. Pending is evaluated combinationally every cycle.
- A requester must not toggle `req[i]` again while it is pending. Double toggles are not detected; the request is simply withdrawn.
- Arbitration is round-robin. Search starts at `last+1` and wraps modulo `N_REQ`; the first pending index wins. `last` is the most recent grant and resets to `N_REQ-1`, so requester 0 wins first.
- FSM states: IDLE, START, ID, DATA, GAP.
  - IDLE: `dout`=0. If any requester is pending, go to START at the next edge.
  - On entering START:
    - latch the winner into `grant_id`;
    - load the shift register with `{grant_id, data[winner]}`;
    - update `last`.
  - START: `dout`=1 for one cycle, then go to ID.
  - ID: `ID_W` cycles; `dout` carries the ID MSB-first.
  - DATA: `DATA_W` cycles; `dout` carries the data MSB-first. Counter width is `$clog2(max(ID_W,DATA_W))+1`.
  - `ack[grant_id]` toggles on the edge that ends the last DATA bit, which is the same edge that enters GAP.
  - GAP: `dout`=0 for one cycle. Arbitration is evaluated in GAP exactly as in IDLE. If a requester is pending, go directly to START; otherwise go to IDLE.
- Frame length is `2+ID_W+DATA_W` cycles (12 with defaults). Back-to-back start bits are 12 cycles apart; there is no IDLE cycle between frames.
- `data` is sampled only at grant. The requester may change `data` after `ack` toggles.
- Simultaneous events:
  - A req toggle in the same cycle as that requester's ack toggle counts as a new pending request. Requesters must not do this; they wait for `ack`.
  - Several pending requesters in one cycle are served in round-robin order.
- Reset mid-frame: the frame is abandoned. No ack toggles for the aborted word. The producer must also return `req` to 0 under reset.

## Timing
- Reset values: `dout`=0, `ack`=0, `busy`=0, `grant_id`=0, state IDLE, `last`=`N_REQ-1`, shift register and counters 0.
- Latency: a req toggle seen at edge k in IDLE puts `dout`=1 (start bit) after edge k.
- `busy` rises with START and falls on the edge leaving GAP to IDLE.
- `ack` toggles `1+ID_W+DATA_W` cycles after START begins.
- Only `ack`, `dout`, `busy` and `grant_id` are outputs, and all are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold `rst` for 5 cycles with random `req` → `dout`=0, `ack`=4'b0000, `busy`=0, `grant_id`=0 on every cycle of reset.
- Single word: `data[1]`=8'hA5, toggle `req[1]` → `dout` sequence 1,0,1,1,0,1,0,0,1,0,1,0. `ack[1]` toggles 11 cycles after the start bit; `busy` lasts 12 cycles.
- Contention: toggle all four `req` in one cycle with data 8'h11/22/33/44 → frames in ID order 0,1,2,3. Start bits 12 cycles apart with no idle cycle. Each `ack` toggles once, in order.
- Fairness: req0 re-toggles in the cycle after each `ack[0]` while req2 stays pending → grants alternate 0,2,0,2. Requester 0 never wins twice in a row.
- Mid-frame reset: assert `rst` during the 3rd DATA bit of a requester-2 frame → next cycle `dout`=0, `ack`=0, `busy`=0. After release, toggling `req[2]` yields a complete fresh frame with ID bits 1,0.
- GAP chaining: requester 3 toggles `req` while requester 0's frame is in DATA → start bit for ID 3 immediately follows the single GAP cycle.

Source files
------------

// File: rtl/serdes_tx_arbiter.sv
// Round-robin arbiter that frames one producer word at a time onto a serial link:
// start bit, requester ID MSB-first, data MSB-first, then a one-cycle gap.
module serdes_tx_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   data,
  output logic [N_REQ-1:0]          ack,
  output logic                      dout,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int SR_W  = ID_W + DATA_W;
  localparam int MAX_W = (ID_W > DATA_W) ? ID_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W) + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_ID, S_DATA, S_GAP} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              dout_q, dout_d;
  logic              busy_q, busy_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [N_REQ-1:0]  pending;
  logic              any_pending;
  logic              found;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   cand;
  int                arb_idx;
  logic [DATA_W-1:0] word_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign word_arr[g] = data[g*DATA_W +: DATA_W];
  end

  // Search starts one past the previous grant so every requester gets a turn.
  always_comb begin
    pending     = req ^ ack_q;
    any_pending = |pending;
    found       = 1'b0;
    winner      = '0;
    cand        = '0;
    arb_idx     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      arb_idx = (int'(last_q) + i) % N_REQ;
      cand    = ID_W'(arb_idx);
      if (!found && pending[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // NOTE: every next-state signal gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    dout_d  = 1'b0;
    grant_d = grant_q;
    last_d  = last_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_GAP: begin
        if (any_pending) begin
          state_d = S_START;
          dout_d  = 1'b1;
          grant_d = winner;
          last_d  = winner;
          sr_d    = {winner, word_arr[winner]};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_ID;
        dout_d  = sr_q[SR_W-1];
        sr_d    = {sr_q[SR_W-2:0], 1'b0};
        cnt_d   = CNT_W'(ID_W - 1);
      end
      S_ID: begin
        dout_d = sr_q[SR_W-1];
        sr_d   = {sr_q[SR_W-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = CNT_W'(DATA_W - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          // Last data bit is done: release the producer as the gap starts.
          state_d        = S_GAP;
          ack_d[grant_q] = ~ack_q[grant_q];
        end else begin
          dout_d = sr_q[SR_W-1];
          sr_d   = {sr_q[SR_W-2:0], 1'b0};
          cnt_d  = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ack_q   <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack      = ack_q;
  assign dout     = dout_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_serdes_tx_arbiter.sv
// Directed bench for serdes_tx_arbiter: reset, single word, contention,
// fairness, mid-frame reset and gap chaining with hand-computed frames.
module tb_serdes_tx_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;
  localparam int ID_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*DATA_W-1:0]  data;
  logic [N_REQ-1:0]         ack;
  logic                     dout;
  logic                     busy;
  logic [ID_W-1:0]          grant_id;

  int               checks   = 0;
  int               failures = 0;
  logic [N_REQ-1:0] exp_ack;

  serdes_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data     (data),
    .ack      (ack),
    .dout     (dout),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walks one 12-cycle frame; bits[11] is the start bit. inj_mask toggles req at cycle inj_cyc.
  task automatic check_frame(input int id, input logic [11:0] bits,
                             input int inj_cyc, input logic [N_REQ-1:0] inj_mask);
    for (int j = 0; j < 12; j++) begin
      tick();
      if (j == 11) exp_ack[id] = ~exp_ack[id];
      check($sformatf("id%0d cyc%0d dout", id, j), 32'(dout), 32'(bits[11-j]));
      check($sformatf("id%0d cyc%0d busy", id, j), 32'(busy), 32'd1);
      check($sformatf("id%0d cyc%0d grant", id, j), 32'(grant_id), 32'(id));
      check($sformatf("id%0d cyc%0d ack", id, j), 32'(ack), 32'(exp_ack));
      if (j == inj_cyc) req = req ^ inj_mask;
    end
  endtask

  task automatic check_idle(input string tag);
    tick();
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " dout"}, 32'(dout), 32'd0);
    check({tag, " ack"},  32'(ack),  32'(exp_ack));
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    data    = {8'h44, 8'h33, 8'h22, 8'h11};
    exp_ack = '0;

    // Reset with random req
    for (int i = 0; i < 5; i++) begin
      req = N_REQ'($urandom);
      tick();
      check($sformatf("rst%0d dout", i),  32'(dout),     32'd0);
      check($sformatf("rst%0d ack", i),   32'(ack),      32'd0);
      check($sformatf("rst%0d busy", i),  32'(busy),     32'd0);
      check($sformatf("rst%0d grant", i), 32'(grant_id), 32'd0);
    end
    req = '0;
    tick();
    rst = 1'b0;
    check_idle("post_rst");

    // Contention: all four at once, served 0,1,2,3 back to back
    req = 4'b1111;
    check_frame(0, 12'h822, -1, '0);
    check_frame(1, 12'hA44, -1, '0);
    check_frame(2, 12'hC66, -1, '0);
    check_frame(3, 12'hE88, -1, '0);
    check_idle("contention_end");

    // Single word A5 from requester 1: 1,0,1,1,0,1,0,0,1,0,1,0
    data[15:8] = 8'hA5;
    req[1]     = ~req[1];
    check_frame(1, 12'hB4A, -1, '0);
    check_idle("single_end");

    // Fairness: 0 and 2 alternate, re-toggling right after their ack
    req[0] = ~req[0];
    check_frame(0, 12'h822, 11, 4'b0101);
    check_frame(2, 12'hC66, 11, 4'b0100);
    check_frame(0, 12'h822, 11, 4'b0001);
    check_frame(2, 12'hC66, -1, '0);
    check_frame(0, 12'h822, -1, '0);
    check_idle("fair_end");

    // Gap chaining: req3 toggles during requester 0's DATA phase
    req[0] = ~req[0];
    check_frame(0, 12'h822, 5, 4'b1000);
    check_frame(3, 12'hE88, -1, '0);
    check_idle("chain_end");

    // Mid-frame reset during the 3rd data bit of a requester-2 frame
    req[2] = ~req[2];
    for (int j = 0; j < 6; j++) begin
      tick();
      check($sformatf("abort cyc%0d dout", j), 32'(dout), 32'((12'hC66 >> (11 - j)) & 12'h1));
      check($sformatf("abort cyc%0d busy", j), 32'(busy), 32'd1);
    end
    rst = 1'b1;
    req = '0;
    tick();
    exp_ack = '0;
    check("abort dout",  32'(dout),     32'd0);
    check("abort ack",   32'(ack),      32'd0);
    check("abort busy",  32'(busy),     32'd0);
    check("abort grant", 32'(grant_id), 32'd0);
    rst = 1'b0;
    check_idle("abort_release");

    // Fresh requester-2 frame after reset, ID bits 1,0
    req[2] = 1'b1;
    check_frame(2, 12'hC66, -1, '0);
    check_idle("fresh_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
